// File: rtl/gain_pkg.sv
// Shared types and helpers for the gain ramp / gain multiplier blocks.
package gain_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StUp,
        StDown
    } ramp_state_e;

    // Unity gain in ufi(w, w/2) format.
    function automatic logic [31:0] coef_unity(input int unsigned w);
        return 32'd1 << (w / 2);
    endfunction

endpackage

// File: rtl/gain_ramp_step.sv
// Combinational ramp step: moves coef one step toward eff, clamped so it never overshoots.
module gain_ramp_step
    import gain_pkg::*;
#(
    parameter int unsigned COEF_WDT = 16
) (
    input  logic [COEF_WDT-1:0] coef_i,
    input  logic [COEF_WDT-1:0] eff_i,
    input  logic [COEF_WDT-1:0] step_i,
    output logic [COEF_WDT-1:0] coef_nxt_o,
    output ramp_state_e         dir_o
);

    logic [COEF_WDT:0] diff_up;
    logic [COEF_WDT:0] diff_dn;
    logic [COEF_WDT:0] step_ext;

    always_comb begin
        step_ext   = {1'b0, step_i};
        diff_up    = {1'b0, eff_i} - {1'b0, coef_i};
        diff_dn    = {1'b0, coef_i} - {1'b0, eff_i};
        dir_o      = StIdle;
        coef_nxt_o = coef_i;
        // The add/subtract only happens when the remaining distance exceeds step, so no wrap.
        if (coef_i < eff_i) begin
            dir_o      = StUp;
            coef_nxt_o = (diff_up <= step_ext) ? eff_i : coef_i + step_i;
        end else if (coef_i > eff_i) begin
            dir_o      = StDown;
            coef_nxt_o = (diff_dn <= step_ext) ? eff_i : coef_i - step_i;
        end
        if (step_i == '0) begin
            coef_nxt_o = eff_i;
        end
    end

endmodule

// File: rtl/gain_ramp.sv
// Sample pipeline plus zipper-free gain coefficient ramp feeding the gain multiplier.
// Optional mute input enabled by defining GAIN_RAMP_MUTE_EN.
module gain_ramp
    import gain_pkg::*;
#(
    parameter int unsigned          A_WDT      = 16,
    parameter int unsigned          COEF_WDT   = 16,
    parameter logic [COEF_WDT-1:0]  RESET_COEF = COEF_WDT'(coef_unity(COEF_WDT))
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                st,
    input  logic [A_WDT-1:0]    a,
    input  logic [COEF_WDT-1:0] tgt,
    input  logic                tgt_we,
    input  logic [COEF_WDT-1:0] step,
`ifdef GAIN_RAMP_MUTE_EN
    input  logic                mute,
`endif
    output logic                st_o,
    output logic [A_WDT-1:0]    a_o,
    output logic [COEF_WDT-1:0] coef,
    output logic                busy
);

    logic                st_q, st_d;
    logic [A_WDT-1:0]    a_q, a_d;
    logic [COEF_WDT-1:0] coef_q, coef_d;
    logic [COEF_WDT-1:0] tgt_q, tgt_d;
    ramp_state_e         state_q, state_d;

    logic [COEF_WDT-1:0] eff_cur, eff_nxt;
    logic [COEF_WDT-1:0] coef_step;
    ramp_state_e         dir_cur;

`ifdef GAIN_RAMP_MUTE_EN
    assign eff_cur = mute ? '0 : tgt_q;
    assign eff_nxt = mute ? '0 : tgt_d;
`else
    assign eff_cur = tgt_q;
    assign eff_nxt = tgt_d;
`endif

    gain_ramp_step #(
        .COEF_WDT(COEF_WDT)
    ) u_step (
        .coef_i    (coef_q),
        .eff_i     (eff_cur),
        .step_i    (step),
        .coef_nxt_o(coef_step),
        .dir_o     (dir_cur)
    );

    always_comb begin
        st_d   = st;
        a_d    = st ? a : a_q;
        tgt_d  = tgt_we ? tgt : tgt_q;
        // Step uses the old target on a coincident write; new target applies from the next strobe.
        coef_d = st ? coef_step : coef_q;
        if (coef_d == eff_nxt) begin
            state_d = StIdle;
        end else if (coef_d < eff_nxt) begin
            state_d = StUp;
        end else begin
            state_d = StDown;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q    <= 1'b0;
            a_q     <= '0;
            coef_q  <= RESET_COEF;
            tgt_q   <= RESET_COEF;
            state_q <= StIdle;
        end else begin
            st_q    <= st_d;
            a_q     <= a_d;
            coef_q  <= coef_d;
            tgt_q   <= tgt_d;
            state_q <= state_d;
        end
    end

    assign st_o = st_q;
    assign a_o  = a_q;
    assign coef = coef_q;
    assign busy = (state_q != StIdle);

    logic unused_dir;
    assign unused_dir = ^dir_cur;

endmodule

// File: tb/tb_gain_ramp.sv
// Directed bench for gain_ramp (default build): scoreboard of expected per-cycle outputs.
module tb_gain_ramp;

    logic        clk = 1'b0;
    logic        reset;
    logic        st;
    logic [15:0] a;
    logic [15:0] tgt;
    logic        tgt_we;
    logic [15:0] step;
    logic        st_o;
    logic [15:0] a_o;
    logic [15:0] coef;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        st_o;
        logic [15:0] a_o;
        logic [15:0] coef;
        logic        busy;
    } exp_t;

    exp_t sb[$];
    logic [15:0] a_model = 16'h0000;

    gain_ramp dut (
        .clk   (clk),
        .reset (reset),
        .st    (st),
        .a     (a),
        .tgt   (tgt),
        .tgt_we(tgt_we),
        .step  (step),
        .st_o  (st_o),
        .a_o   (a_o),
        .coef  (coef),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, push expected outputs, then pop and compare after the edge.
    task automatic cyc(input string tag, input logic s, input logic [15:0] av, input logic we,
                       input logic [15:0] tv, input logic [15:0] sv,
                       input logic [15:0] ecoef, input logic ebusy);
        exp_t e;
        exp_t got;
        @(negedge clk);
        st = s; a = av; tgt_we = we; tgt = tv; step = sv;
        if (s) a_model = av;
        e.st_o = s; e.a_o = a_model; e.coef = ecoef; e.busy = ebusy;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk({tag, ".st_o"}, {31'd0, st_o}, {31'd0, got.st_o});
        chk({tag, ".a_o"},  {16'd0, a_o},  {16'd0, got.a_o});
        chk({tag, ".coef"}, {16'd0, coef}, {16'd0, got.coef});
        chk({tag, ".busy"}, {31'd0, busy}, {31'd0, got.busy});
        st = 1'b0; tgt_we = 1'b0;
    endtask

    initial begin
        reset = 1'b1; st = 1'b0; a = '0; tgt = '0; tgt_we = 1'b0; step = '0;
        #12;
        chk("rst.st_o", {31'd0, st_o}, 32'd0);
        chk("rst.a_o",  {16'd0, a_o},  32'd0);
        chk("rst.coef", {16'd0, coef}, 32'h0100);
        chk("rst.busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Idle strobe, then a_o holds while st=0 with different a.
        cyc("idle", 1'b1, 16'h1234, 1'b0, 16'h0000, 16'h0000, 16'h0100, 1'b0);
        cyc("hold", 1'b0, 16'hBEEF, 1'b0, 16'h0000, 16'h0000, 16'h0100, 1'b0);

        // Ramp up 0x0100 -> 0x0200 in steps of 0x0040.
        cyc("tgt_up", 1'b0, 16'h0, 1'b1, 16'h0200, 16'h0040, 16'h0100, 1'b1);
        cyc("up1", 1'b1, 16'h0001, 1'b0, 16'h0, 16'h0040, 16'h0140, 1'b1);
        cyc("up2", 1'b1, 16'h0002, 1'b0, 16'h0, 16'h0040, 16'h0180, 1'b1);
        cyc("up3", 1'b1, 16'h0003, 1'b0, 16'h0, 16'h0040, 16'h01C0, 1'b1);
        cyc("up4", 1'b1, 16'h0004, 1'b0, 16'h0, 16'h0040, 16'h0200, 1'b0);

        // Back to unity via a jump, then clamp down to 0x00F0.
        cyc("tgt_1", 1'b0, 16'h0, 1'b1, 16'h0100, 16'h0000, 16'h0200, 1'b1);
        cyc("jump1", 1'b1, 16'h0005, 1'b0, 16'h0, 16'h0000, 16'h0100, 1'b0);
        cyc("tgt_f0", 1'b0, 16'h0, 1'b1, 16'h00F0, 16'h0040, 16'h0100, 1'b1);
        cyc("clamp", 1'b1, 16'h0006, 1'b0, 16'h0, 16'h0040, 16'h00F0, 1'b0);

        // Redirect mid-ramp with a write coincident with a strobe.
        cyc("tgt_1b", 1'b0, 16'h0, 1'b1, 16'h0100, 16'h0000, 16'h00F0, 1'b1);
        cyc("jump2", 1'b1, 16'h0007, 1'b0, 16'h0, 16'h0000, 16'h0100, 1'b0);
        cyc("tgt_2", 1'b0, 16'h0, 1'b1, 16'h0200, 16'h0040, 16'h0100, 1'b1);
        cyc("rd1", 1'b1, 16'h0011, 1'b0, 16'h0, 16'h0040, 16'h0140, 1'b1);
        cyc("rd2", 1'b1, 16'h0012, 1'b0, 16'h0, 16'h0040, 16'h0180, 1'b1);
        cyc("rd3", 1'b1, 16'h0013, 1'b1, 16'h0100, 16'h0040, 16'h01C0, 1'b1);
        cyc("rd4", 1'b1, 16'h0014, 1'b0, 16'h0, 16'h0040, 16'h0180, 1'b1);
        cyc("rd5", 1'b1, 16'h0015, 1'b0, 16'h0, 16'h0040, 16'h0140, 1'b1);
        cyc("rd6", 1'b1, 16'h0016, 1'b0, 16'h0, 16'h0040, 16'h0100, 1'b0);

        // Boundaries: jump to zero, then ramp up to all-ones without wrapping.
        cyc("tgt_0", 1'b0, 16'h0, 1'b1, 16'h0000, 16'h0000, 16'h0100, 1'b1);
        cyc("zero", 1'b1, 16'h0021, 1'b0, 16'h0, 16'h0000, 16'h0000, 1'b0);
        cyc("tgt_ff", 1'b0, 16'h0, 1'b1, 16'hFFFF, 16'hF000, 16'h0000, 1'b1);
        cyc("big1", 1'b1, 16'h0022, 1'b0, 16'h0, 16'hF000, 16'hF000, 1'b1);
        cyc("big2", 1'b1, 16'h0023, 1'b0, 16'h0, 16'hF000, 16'hFFFF, 1'b0);

        // Jump from unity straight to all-ones with step=0.
        cyc("tgt_1c", 1'b0, 16'h0, 1'b1, 16'h0100, 16'h0000, 16'hFFFF, 1'b1);
        cyc("jump3", 1'b1, 16'h0024, 1'b0, 16'h0, 16'h0000, 16'h0100, 1'b0);
        cyc("tgt_ff2", 1'b0, 16'h0, 1'b1, 16'hFFFF, 16'h0000, 16'h0100, 1'b1);
        cyc("jumpff", 1'b1, 16'h0025, 1'b0, 16'h0, 16'h0000, 16'hFFFF, 1'b0);

        // Asynchronous reset in the middle of a slow ramp down.
        cyc("tgt_00", 1'b0, 16'h0, 1'b1, 16'h0000, 16'h0001, 16'hFFFF, 1'b1);
        cyc("slow1", 1'b1, 16'h0031, 1'b0, 16'h0, 16'h0001, 16'hFFFE, 1'b1);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        chk("arst.coef", {16'd0, coef}, 32'h0100);
        chk("arst.busy", {31'd0, busy}, 32'd0);
        chk("arst.a_o",  {16'd0, a_o},  32'd0);
        @(negedge clk);
        reset = 1'b0;
        a_model = 16'h0000;
        cyc("post", 1'b1, 16'h0041, 1'b0, 16'h0, 16'h0001, 16'h0100, 1'b0);

        chk("sb_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
